// File: rtl/if_id_queue_pkg.sv
// ============================================================================
// Module      : if_id_queue_pkg
// Description : Shared word width, NOP encoding and clog2 helper for the IF/ID path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_id_queue_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  // Bits needed to encode values 0..value-1; at least 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_queue_mem.sv
// ============================================================================
// Module      : if_id_queue_mem
// Description : DEPTH x WIDTH register file, one synchronous write, one async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int WIDTH = 2 * WORD_W,
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/if_id_queue.sv
// ============================================================================
// Module      : if_id_queue
// Description : In-order IF->ID decoupling FIFO with valid/ready handshake and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int                DATA_W = WORD_W,
  parameter int                DEPTH  = 4,
  parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_INSN)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_pc,
  input  logic [DATA_W-1:0]           in_instruction,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_pc,
  output logic [DATA_W-1:0]           out_instruction,
  input  logic                        out_ready,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int                PTR_W    = clog2(DEPTH);
  localparam int                CNT_W    = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  C_FULL   = CNT_W'(DEPTH);

  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_push;
  logic                w_pop;
  logic [2*DATA_W-1:0] w_rdata;

  // Readiness never looks at out_ready: a full queue refuses even while popping.
  assign in_ready  = (r_count < C_FULL) & ~flush;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign count     = r_count;

  assign out_pc          = out_valid ? w_rdata[2*DATA_W-1:DATA_W] : '0;
  assign out_instruction = out_valid ? w_rdata[DATA_W-1:0]        : NOP;

  if_id_queue_mem #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK   (CLK),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata ({in_pc, in_instruction}),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  // Pointers are power-of-two wide, so natural overflow gives the modulo wrap.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire
